glb_port_arbiter: RTL and testbench
===================================

# glb_port_arbiter

Two-master arbiter that shares the single GLB read/write port pair between the pass controller (master 0) and the tiling DRAM mover (master 1). It replaces the static state-based mux in front of the GLB: it grants per-cycle access with round-robin fairness and optional bounded bursts, and returns read data to the correct master after the GLB read latency. It sits between both masters and the GLB instance inside the top-level accelerator.

## Interface
- `ADDR_BITS`, 32, byte-address width.
- `DATA_BITS`, 32, data width.
- `RD_LAT`, 1, GLB read latency in cycles (1..4).
- `MAX_BURST`, 16, maximum consecutive locked grants while the other master waits (2..255).

- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `mN_req`  in  1  master N (N=0,1) request valid.
- `mN_lock`  in  1  master N asks to keep the grant next cycle.
- `mN_we`  in  4  byte write enables.
- `mN_re`  in  4  byte read enables.
- `mN_w_addr`, `mN_r_addr`  in  ADDR_BITS  write and read byte addresses.
- `mN_wdata`  in  DATA_BITS  write data.
- `mN_gnt`  out  1  request accepted this cycle.
- `mN_rvalid`  out  1  read data valid for master N.
- `mN_rdata`  out  DATA_BITS  read data; equals `glb_dout` when `mN_rvalid`=1, otherwise 0.
- `glb_we`, `glb_re`  out  4  GLB enables.
- `glb_w_addr`, `glb_r_addr`  out  ADDR_BITS  GLB addresses.
- `glb_din`  out  DATA_BITS  GLB write data.
- `glb_dout`  in  DATA_BITS  GLB read data.
- `busy`  out  1  a grant is active, or a read is in flight.

## Operation
- A transaction is one cycle with `req`=1. It may carry writes (`we`≠0), reads (`re`≠0), or both. Both GLB ports are used in the same cycle.
- The winner is decided combinationally each cycle:
  - Lock owner, if its burst is active.
  - Else the only requester.
  - Else, if both request, the master named by priority pointer `prio`.
- The winner's `gnt` is 1. The loser's `gnt` is 0 and it holds its request stable.
- GLB outputs mirror the winner's `we`/`re`/addr/wdata. With no winner, `glb_we`=`glb_re`=0 and addresses and data are 0.
- `prio` register:
  - After any grant with contention, it points to the loser.
  - After an uncontended grant, it points to the other master.
- Lock/burst:
  - If the winner has `lock`=1 at grant, it becomes owner next cycle and `burst_cnt` increments. `burst_cnt` is 8-bit, saturating at MAX_BURST.
  - Ownership ends when the owner drops `req` or `lock`.
  - If the other master requests while `burst_cnt`==MAX_BURST, ownership is forced off and the other master wins that cycle.
  - `burst_cnt` clears when ownership ends.
- Read return:
  - A shift register RD_LAT deep carries {valid, master_id} for every granted read.
  - At the tail, `mN_rvalid` asserts for the tagged master.
  - Returns stay in order and are independent of later grants.

## Timing
- `gnt` and the `glb_*` drive are same-cycle, combinational from `req`/`lock`/state.
- `rvalid` asserts exactly RD_LAT cycles after the granting edge. With RD_LAT=1: read granted in cycle T, so `rvalid` and `rdata` appear in T+1.
- Back-to-back reads from alternating masters need no bubbles. One grant per cycle.
- Reset (`rst`=0), applied asynchronously:
  - `prio`=0, owner none, `burst_cnt`=0, read pipeline cleared.
  - All `gnt`, `rvalid`, `rdata`, `glb_we`/`glb_re`, addresses, `glb_din` and `busy` are 0.
  - Reads in flight at reset are dropped; no `rvalid` is produced for them after release.
- `req` with `we`=`re`=0 is still granted. It counts for `prio`/burst but drives no GLB enables.
- Lock owner drops `req` while the other master requests: the other master is granted in that same cycle.

## Configuration
- `GLB_ARB_PERF_EN` defined adds these outputs, each cleared by reset:
  - `perf_gnt0`, `perf_gnt1` (32-bit): grant counts.
  - `perf_stall0`, `perf_stall1` (32-bit): cycles with `req`=1 and `gnt`=0.
  - All four saturate at 2^32-1.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Reset release, idle: all outputs 0. Single m0 read at 0x40, with `glb_dout`=0xDEADBEEF in T+1: `m0_gnt`=1 in T; `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF in T+1; `m1_rvalid`=0.
- Both masters request reads continuously for 6 cycles after reset, no lock: grants alternate m0,m1,m0,m1,m0,m1. Each `rvalid` returns to the matching master one cycle later.
- m1 locked with MAX_BURST=4 while m0 requests throughout: m1 gets 4 grants, then m0 is granted in cycle 5. Then `prio` and round-robin resume.
- Same cycle: m0 writes 0xA5A5A5A5 to 0x100 with `we`=4'hF while reading 0x104: `glb_we`=4'hF, `glb_w_addr`=0x100, `glb_re`=4'hF, `glb_r_addr`=0x104.
- Reset asserted the cycle after a read grant with RD_LAT=2: no `rvalid` at any time after reset release; `busy`=0.
- With `GLB_ARB_PERF_EN`, contended 6-cycle run: `perf_gnt0`=3, `perf_gnt1`=3, and `perf_stall0` + `perf_stall1` = 6.

Source files
------------

// File: rtl/glb_port_arbiter_if.sv
// glb_port_arbiter_if: bundles both master request/response channels and the
// shared GLB read/write port pair seen by glb_port_arbiter.
// slave  : arbiter side (takes master requests and GLB read data, drives grants/GLB).
// master : environment side (the two masters plus the GLB instance).
interface glb_port_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic                 m0_req;
  logic                 m0_lock;
  logic [3:0]           m0_we;
  logic [3:0]           m0_re;
  logic [ADDR_BITS-1:0] m0_w_addr;
  logic [ADDR_BITS-1:0] m0_r_addr;
  logic [DATA_BITS-1:0] m0_wdata;
  logic                 m0_gnt;
  logic                 m0_rvalid;
  logic [DATA_BITS-1:0] m0_rdata;

  logic                 m1_req;
  logic                 m1_lock;
  logic [3:0]           m1_we;
  logic [3:0]           m1_re;
  logic [ADDR_BITS-1:0] m1_w_addr;
  logic [ADDR_BITS-1:0] m1_r_addr;
  logic [DATA_BITS-1:0] m1_wdata;
  logic                 m1_gnt;
  logic                 m1_rvalid;
  logic [DATA_BITS-1:0] m1_rdata;

  logic [3:0]           glb_we;
  logic [3:0]           glb_re;
  logic [ADDR_BITS-1:0] glb_w_addr;
  logic [ADDR_BITS-1:0] glb_r_addr;
  logic [DATA_BITS-1:0] glb_din;
  logic [DATA_BITS-1:0] glb_dout;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_re, m0_w_addr, m0_r_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_lock, m1_we, m1_re, m1_w_addr, m1_r_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output glb_we, glb_re, glb_w_addr, glb_r_addr, glb_din,
    input  glb_dout
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_re, m0_w_addr, m0_r_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_lock, m1_we, m1_re, m1_w_addr, m1_r_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  glb_we, glb_re, glb_w_addr, glb_r_addr, glb_din,
    output glb_dout
  );
endinterface

// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: shares one GLB read/write port pair between the pass
// controller (master 0) and the tiling DRAM mover (master 1). Per-cycle
// round-robin grant, optional bounded lock bursts, and read data steered back
// to the requesting master after RD_LAT cycles.
// Optional feature: define GLB_ARB_PERF_EN to add saturating grant/stall counters.
module glb_port_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  glb_port_arbiter_if.slave     bus,
  output logic                  busy
`ifdef GLB_ARB_PERF_EN
  ,
  output logic [31:0]           perf_gnt0,
  output logic [31:0]           perf_gnt1,
  output logic [31:0]           perf_stall0,
  output logic [31:0]           perf_stall1
`endif
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v >= MAX_B) ? MAX_B : v + 8'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic              prio_q, prio_d;
  logic              own_q, own_d;
  logic              own_id_q, own_id_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0] rd_id_q, rd_id_d;

  logic req0, req1, own_req, oth_req;
  logic force_off, own_active;
  logic win_vld, win_id, win_lock, rd_new;

  // Winner selection: active lock owner, then sole requester, then prio.
  // Requests are masked while reset is asserted so nothing is granted.
  always_comb begin
    req0       = bus.m0_req & rst;
    req1       = bus.m1_req & rst;
    own_req    = own_id_q ? req1 : req0;
    oth_req    = own_id_q ? req0 : req1;
    force_off  = own_q && own_req && oth_req && (burst_cnt_q == MAX_B);
    own_active = own_q && own_req && !force_off;
    win_vld    = req0 | req1;
    if (own_active)        win_id = own_id_q;
    else if (force_off)    win_id = ~own_id_q;
    else if (req0 && req1) win_id = prio_q;
    else                   win_id = req1;
    win_lock   = win_id ? bus.m1_lock : bus.m0_lock;
  end

  // GLB port mux and grant outputs; idle port drives all zeros.
  always_comb begin
    bus.glb_we     = '0;
    bus.glb_re     = '0;
    bus.glb_w_addr = '0;
    bus.glb_r_addr = '0;
    bus.glb_din    = '0;
    if (win_vld) begin
      bus.glb_we     = win_id ? bus.m1_we     : bus.m0_we;
      bus.glb_re     = win_id ? bus.m1_re     : bus.m0_re;
      bus.glb_w_addr = win_id ? bus.m1_w_addr : bus.m0_w_addr;
      bus.glb_r_addr = win_id ? bus.m1_r_addr : bus.m0_r_addr;
      bus.glb_din    = win_id ? bus.m1_wdata  : bus.m0_wdata;
    end
    bus.m0_gnt = win_vld & ~win_id;
    bus.m1_gnt = win_vld &  win_id;
  end

  // Next state: prio flips to the non-winner on every grant; a locked grant
  // (re)starts or extends ownership; the read tag pipe shifts every cycle.
  always_comb begin
    prio_d      = prio_q;
    own_d       = 1'b0;
    own_id_d    = own_id_q;
    burst_cnt_d = '0;
    rd_new      = win_vld && (bus.glb_re != 4'd0);
    if (win_vld) begin
      prio_d = ~win_id;
      if (win_lock) begin
        own_d       = 1'b1;
        own_id_d    = win_id;
        burst_cnt_d = own_active ? sat_inc8(burst_cnt_q) : 8'd1;
      end
    end
    rd_vld_d    = rd_vld_q;
    rd_id_d     = rd_id_q;
    rd_vld_d[0] = rd_new;
    rd_id_d[0]  = win_id;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_id_d[i]  = rd_id_q[i-1];
    end
  end

  // Arbitration state and read-return pipe; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= 1'b0;
      own_q       <= 1'b0;
      own_id_q    <= 1'b0;
      burst_cnt_q <= '0;
      rd_vld_q    <= '0;
      rd_id_q     <= '0;
    end else begin
      prio_q      <= prio_d;
      own_q       <= own_d;
      own_id_q    <= own_id_d;
      burst_cnt_q <= burst_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_id_q     <= rd_id_d;
    end
  end

  // Read return: tail of the tag pipe selects which master sees glb_dout.
  always_comb begin
    bus.m0_rvalid = rd_vld_q[RD_LAT-1] & ~rd_id_q[RD_LAT-1];
    bus.m1_rvalid = rd_vld_q[RD_LAT-1] &  rd_id_q[RD_LAT-1];
    bus.m0_rdata  = bus.m0_rvalid ? bus.glb_dout : '0;
    bus.m1_rdata  = bus.m1_rvalid ? bus.glb_dout : '0;
    busy          = win_vld | (|rd_vld_q);
  end

`ifdef GLB_ARB_PERF_EN
  logic [31:0] perf_gnt0_q, perf_gnt0_d, perf_gnt1_q, perf_gnt1_d;
  logic [31:0] perf_stall0_q, perf_stall0_d, perf_stall1_q, perf_stall1_d;

  // Saturating grant and stall counters.
  always_comb begin
    perf_gnt0_d   = bus.m0_gnt ? sat_inc32(perf_gnt0_q) : perf_gnt0_q;
    perf_gnt1_d   = bus.m1_gnt ? sat_inc32(perf_gnt1_q) : perf_gnt1_q;
    perf_stall0_d = (req0 && !bus.m0_gnt) ? sat_inc32(perf_stall0_q) : perf_stall0_q;
    perf_stall1_d = (req1 && !bus.m1_gnt) ? sat_inc32(perf_stall1_q) : perf_stall1_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_gnt0_q   <= '0;
      perf_gnt1_q   <= '0;
      perf_stall0_q <= '0;
      perf_stall1_q <= '0;
    end else begin
      perf_gnt0_q   <= perf_gnt0_d;
      perf_gnt1_q   <= perf_gnt1_d;
      perf_stall0_q <= perf_stall0_d;
      perf_stall1_q <= perf_stall1_d;
    end
  end

  assign perf_gnt0   = perf_gnt0_q;
  assign perf_gnt1   = perf_gnt1_q;
  assign perf_stall0 = perf_stall0_q;
  assign perf_stall1 = perf_stall1_q;
`endif

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Directed bench for glb_port_arbiter. dut_a: RD_LAT=1, MAX_BURST=4.
// dut_b: RD_LAT=2, MAX_BURST=16.
module tb_glb_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic busy_a, busy_b;
  int   checks   = 0;
  int   failures = 0;

  glb_port_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32)) ifa ();
  glb_port_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32)) ifb ();

`ifdef GLB_ARB_PERF_EN
  logic [31:0] pa_g0, pa_g1, pa_s0, pa_s1, pb_g0, pb_g1, pb_s0, pb_s1;
`endif

  glb_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .RD_LAT(1), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave), .busy(busy_a)
`ifdef GLB_ARB_PERF_EN
    , .perf_gnt0(pa_g0), .perf_gnt1(pa_g1), .perf_stall0(pa_s0), .perf_stall1(pa_s1)
`endif
  );

  glb_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .RD_LAT(2), .MAX_BURST(16)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave), .busy(busy_b)
`ifdef GLB_ARB_PERF_EN
    , .perf_gnt0(pb_g0), .perf_gnt1(pb_g1), .perf_stall0(pb_s0), .perf_stall1(pb_s1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    ifa.m0_req = 0; ifa.m0_lock = 0; ifa.m0_we = 0; ifa.m0_re = 0;
    ifa.m0_w_addr = 0; ifa.m0_r_addr = 0; ifa.m0_wdata = 0;
    ifa.m1_req = 0; ifa.m1_lock = 0; ifa.m1_we = 0; ifa.m1_re = 0;
    ifa.m1_w_addr = 0; ifa.m1_r_addr = 0; ifa.m1_wdata = 0;
  endtask

  task automatic clr_b();
    ifb.m0_req = 0; ifb.m0_lock = 0; ifb.m0_we = 0; ifb.m0_re = 0;
    ifb.m0_w_addr = 0; ifb.m0_r_addr = 0; ifb.m0_wdata = 0;
    ifb.m1_req = 0; ifb.m1_lock = 0; ifb.m1_we = 0; ifb.m1_re = 0;
    ifb.m1_w_addr = 0; ifb.m1_r_addr = 0; ifb.m1_wdata = 0;
  endtask

  initial begin
    rst_a = 0; rst_b = 0;
    clr_a(); clr_b();
    ifa.glb_dout = 0; ifb.glb_dout = 0;

    // Reset state, even with a request pending
    tick();
    ifa.m0_req = 1; ifa.m0_re = 4'hF; ifa.m0_r_addr = 32'h40;
    #1;
    chk("rst_m0_gnt", ifa.m0_gnt, 0);
    chk("rst_glb_re", ifa.glb_re, 0);
    chk("rst_glb_r_addr", ifa.glb_r_addr, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_m0_rvalid", ifa.m0_rvalid, 0);
    clr_a();
    tick();
    rst_a = 1;
    #1;
    chk("idle_m0_gnt", ifa.m0_gnt, 0);
    chk("idle_m1_gnt", ifa.m1_gnt, 0);
    chk("idle_glb_we", ifa.glb_we, 0);
    chk("idle_busy", busy_a, 0);
    chk("idle_m1_rdata", ifa.m1_rdata, 0);

    // Single m0 read at 0x40
    tick();
    ifa.m0_req = 1; ifa.m0_re = 4'hF; ifa.m0_r_addr = 32'h40;
    #1;
    chk("rd_m0_gnt", ifa.m0_gnt, 1);
    chk("rd_m1_gnt", ifa.m1_gnt, 0);
    chk("rd_glb_re", ifa.glb_re, 4'hF);
    chk("rd_glb_r_addr", ifa.glb_r_addr, 32'h40);
    chk("rd_busy", busy_a, 1);
    tick();
    clr_a();
    ifa.glb_dout = 32'hDEADBEEF;
    #1;
    chk("rd_m0_rvalid", ifa.m0_rvalid, 1);
    chk("rd_m0_rdata", ifa.m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", ifa.m1_rvalid, 0);
    chk("rd_m1_rdata", ifa.m1_rdata, 0);

    // Same-cycle write and read
    tick();
    ifa.m0_req = 1; ifa.m0_we = 4'hF; ifa.m0_w_addr = 32'h100;
    ifa.m0_wdata = 32'hA5A5A5A5; ifa.m0_re = 4'hF; ifa.m0_r_addr = 32'h104;
    #1;
    chk("wr_glb_we", ifa.glb_we, 4'hF);
    chk("wr_glb_w_addr", ifa.glb_w_addr, 32'h100);
    chk("wr_glb_din", ifa.glb_din, 32'hA5A5A5A5);
    chk("wr_glb_re", ifa.glb_re, 4'hF);
    chk("wr_glb_r_addr", ifa.glb_r_addr, 32'h104);
    tick();
    clr_a();
    ifa.glb_dout = 32'h0;

    // Fresh reset, then 6 cycles of contended reads
    tick();
    rst_a = 0;
    tick();
    rst_a = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      ifa.m0_req = 1; ifa.m1_req = 1; ifa.m0_re = 4'hF; ifa.m1_re = 4'hF;
      ifa.m0_r_addr = 32'h200 + i; ifa.m1_r_addr = 32'h300 + i;
      ifa.glb_dout = 32'h1000 + i;
      #1;
      chk("rr_m0_gnt", ifa.m0_gnt, (i % 2 == 0));
      chk("rr_m1_gnt", ifa.m1_gnt, (i % 2 == 1));
      chk("rr_glb_r_addr", ifa.glb_r_addr, (i % 2 == 0) ? 32'h200 + i : 32'h300 + i);
      if (i > 0) begin
        chk("rr_m0_rvalid", ifa.m0_rvalid, ((i - 1) % 2 == 0));
        chk("rr_m1_rvalid", ifa.m1_rvalid, ((i - 1) % 2 == 1));
        chk("rr_m0_rdata", ifa.m0_rdata, ((i - 1) % 2 == 0) ? 32'h1000 + i : 32'h0);
        chk("rr_m1_rdata", ifa.m1_rdata, ((i - 1) % 2 == 1) ? 32'h1000 + i : 32'h0);
      end
    end
    tick();
    clr_a();
    ifa.glb_dout = 32'h2000;
    #1;
    chk("rr_last_m1_rvalid", ifa.m1_rvalid, 1);
    chk("rr_last_m1_rdata", ifa.m1_rdata, 32'h2000);
    chk("rr_last_m0_rvalid", ifa.m0_rvalid, 0);
`ifdef GLB_ARB_PERF_EN
    chk("perf_gnt0", pa_g0, 3);
    chk("perf_gnt1", pa_g1, 3);
    chk("perf_stall_sum", pa_s0 + pa_s1, 6);
`endif
    ifa.glb_dout = 32'h0;

    // Burst: m1 locked, m0 waiting; MAX_BURST=4
    tick();
    ifa.m1_req = 1; ifa.m1_lock = 1;
    #1;
    chk("b1_m1_gnt", ifa.m1_gnt, 1);
    chk("b1_m0_gnt", ifa.m0_gnt, 0);
    chk("b1_noen_glb_re", ifa.glb_re, 0);
    chk("b1_noen_glb_we", ifa.glb_we, 0);
    for (int j = 2; j <= 4; j++) begin
      tick();
      ifa.m0_req = 1;
      #1;
      chk("burst_m1_gnt", ifa.m1_gnt, 1);
      chk("burst_m0_gnt", ifa.m0_gnt, 0);
    end
    tick();
    #1;
    chk("b5_m0_gnt", ifa.m0_gnt, 1);
    chk("b5_m1_gnt", ifa.m1_gnt, 0);
    tick();
    #1;
    chk("b6_m1_gnt", ifa.m1_gnt, 1);
    tick();
    ifa.m1_lock = 0;
    #1;
    chk("b7_m1_gnt", ifa.m1_gnt, 1);
    tick();
    #1;
    chk("b8_m0_gnt", ifa.m0_gnt, 1);
    tick();
    #1;
    chk("b9_m1_gnt", ifa.m1_gnt, 1);

    // Lock owner drops req while the other master requests
    tick();
    ifa.m0_req = 0; ifa.m1_lock = 1;
    #1;
    chk("b10_m1_gnt", ifa.m1_gnt, 1);
    tick();
    ifa.m1_req = 0; ifa.m0_req = 1;
    #1;
    chk("b11_m0_gnt", ifa.m0_gnt, 1);
    chk("b11_m1_gnt", ifa.m1_gnt, 0);
    tick();
    clr_a();
    #1;
    chk("b12_busy", busy_a, 0);
    chk("b12_m0_rvalid", ifa.m0_rvalid, 0);

    // dut_b: RD_LAT=2 return timing
    tick();
    rst_b = 1;
    tick();
    ifb.m1_req = 1; ifb.m1_re = 4'hF; ifb.m1_r_addr = 32'h80;
    #1;
    chk("l2_m1_gnt", ifb.m1_gnt, 1);
    tick();
    clr_b();
    #1;
    chk("l2_t1_m1_rvalid", ifb.m1_rvalid, 0);
    chk("l2_t1_busy", busy_b, 1);
    tick();
    ifb.glb_dout = 32'hCAFEF00D;
    #1;
    chk("l2_t2_m1_rvalid", ifb.m1_rvalid, 1);
    chk("l2_t2_m1_rdata", ifb.m1_rdata, 32'hCAFEF00D);
    chk("l2_t2_m0_rvalid", ifb.m0_rvalid, 0);
    tick();
    #1;
    chk("l2_t3_m1_rvalid", ifb.m1_rvalid, 0);
    chk("l2_t3_m1_rdata", ifb.m1_rdata, 0);

    // dut_b: reset the cycle after a read grant drops the read
    tick();
    ifb.m0_req = 1; ifb.m0_re = 4'hF; ifb.m0_r_addr = 32'h44;
    #1;
    chk("rr2_m0_gnt", ifb.m0_gnt, 1);
    tick();
    clr_b();
    rst_b = 0;
    #1;
    chk("rr2_busy_in_rst", busy_b, 0);
    chk("rr2_rvalid_in_rst", ifb.m0_rvalid, 0);
    tick();
    tick();
    rst_b = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("rr2_post_m0_rvalid", ifb.m0_rvalid, 0);
      chk("rr2_post_m1_rvalid", ifb.m1_rvalid, 0);
      chk("rr2_post_busy", busy_b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
